compare_tally: RTL and testbench
================================

Name: compare_tally

Overview:
- Downstream consumer of the 4-bit magnitude comparator's one-hot result Y (001 = A>B, 010 = A==B, 100 = A<B).
- Accepts one result per valid/ready handshake and tallies greater, equal and less outcomes over a fixed-length round.
- At round end, publishes the three counts plus a one-hot round verdict, using the same encoding as Y, on a second valid/ready handshake.
- Flags malformed (non-one-hot) inputs.

Parameters:
- ROUND_LEN, 8, number of valid (one-hot) samples per round; legal range 1 to 2**CNT_W-1.
- CNT_W, 4, width of each tally counter; must satisfy ROUND_LEN < 2**CNT_W.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous round abort and error clear, active high.
- in_valid  in  1  comparator result present on y.
- in_ready  out  1  block can accept a sample this cycle.
- y  in  3  comparator one-hot result.
- res_valid  out  1  round result available.
- res_ready  in  1  consumer takes the result.
- gt_cnt  out  CNT_W  count of 001 samples in the round.
- eq_cnt  out  CNT_W  count of 010 samples in the round.
- lt_cnt  out  CNT_W  count of 100 samples in the round.
- verdict  out  3  round verdict: 001 if gt_cnt>lt_cnt, 010 if gt_cnt==lt_cnt, 100 if gt_cnt<lt_cnt.
- err  out  1  sticky: at least one non-one-hot sample accepted since the last reset or clear.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=COLLECT, all counters 0, verdict=3'b000, err=0, res_valid=0, in_ready=1 once out of reset.
- State COLLECT:
  - in_ready=1, res_valid=0.
  - A sample transfers on a rising edge where in_valid && in_ready.
  - y=001 increments gt_cnt; y=010 increments eq_cnt; y=100 increments lt_cnt.
  - Any other y (000, 011, 101, 110, 111) is discarded: no counter changes, it does not count toward ROUND_LEN, err is set to 1.
- Round completion:
  - When a valid transfer makes gt_cnt+eq_cnt+lt_cnt == ROUND_LEN, that same edge registers verdict from the post-increment counts and moves to REPORT.
  - res_valid is high in the cycle after the final accepted sample (1-cycle latency).
- State REPORT:
  - in_ready=0 and res_valid=1.
  - gt_cnt, eq_cnt, lt_cnt and verdict are held stable until the handshake.
  - On an edge with res_ready=1: all counters clear to 0, verdict returns to 000, state goes to COLLECT, and in_ready=1 the following cycle.
  - No sample is accepted in the handshake cycle, even if in_valid=1.
- Outside REPORT: counters show the running tally (monitoring only); verdict=000; res_valid=0.
- Counter arithmetic: unsigned, CNT_W bits. Overflow is impossible given the parameter constraint; no wrap logic is required.
- ROUND_LEN=1: every valid sample immediately produces a report.
- clear:
  - Highest priority among synchronous events, in any state.
  - Zeros counters, verdict and err; forces COLLECT and res_valid=0.
  - A sample presented in the clear cycle is dropped.
  - A pending result in REPORT is discarded without handshake.
- Simultaneous events in COLLECT: the final valid sample together with clear means clear wins and no report is produced. An invalid sample together with clear leaves err=0 (clear wins).
- err: never self-clears; only rst_n or clear reset it. err does not block operation.
- Reset mid-round: asynchronous assertion immediately forces reset values, abandoning any partial tally or pending report.

Test Plan:
- Reset, then 8 samples of y=001 with in_valid held high -> in_ready low after the 8th edge; res_valid=1 next cycle with gt_cnt=8, eq_cnt=0, lt_cnt=0, verdict=001; counters cleared the cycle after res_ready=1.
- Sequence 001,100,010,100,001,010,100,001 -> gt=3, eq=2, lt=3, verdict=010. Repeat with one extra 100 in place of the final 001 -> gt=2, lt=4, verdict=100.
- Inject y=011 and y=000 mid-round among 8 valid samples -> err=1, round still closes after exactly 8 valid samples, counts exclude the bad samples; err stays 1 through the next round until clear pulses.
- Hold res_ready=0 for 5 cycles in REPORT with in_valid=1 and toggling y -> outputs stable, in_ready=0, no counts change. Then assert res_ready -> back to COLLECT with counts 0, and the first sample is accepted one cycle after the handshake.
- Pulse clear on the edge carrying the 8th valid sample -> no res_valid, counts 0, err 0. Separately, assert rst_n=0 between clock edges during REPORT -> res_valid and counts drop to 0 immediately.
- ROUND_LEN=1 build: alternating 100/001 samples, each answered by res_ready the cycle res_valid rises -> alternating verdict 100, 001 with a report every 2 cycles.

Source files
------------

// File: rtl/compare_tally.sv
// compare_tally: consumes one-hot magnitude-comparator results (001 = A>B,
// 010 = A==B, 100 = A<B), tallies them over a fixed-length round and then
// offers the three counts plus a one-hot verdict on a result handshake.
// Non-one-hot samples are dropped and flagged through a sticky err bit.
module compare_tally #(
  parameter int ROUND_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [2:0]       verdict,
  output logic             err
);

  // Two extra bits keep the three-way sum from overflowing.
  localparam int SUM_W = CNT_W + 2;
  localparam logic [SUM_W-1:0] ROUND_TARGET = SUM_W'(ROUND_LEN);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic {
    COLLECT,
    REPORT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] gt_q, gt_d;
  logic [CNT_W-1:0] eq_q, eq_d;
  logic [CNT_W-1:0] lt_q, lt_d;
  logic [2:0]       verdict_q, verdict_d;
  logic             err_q, err_d;
  logic             sample_ok;
  logic [SUM_W-1:0] sum_d;

  // Next-state logic: clear dominates, then collect samples or wait for the
  // result handshake depending on state.
  always_comb begin
    state_d   = state_q;
    gt_d      = gt_q;
    eq_d      = eq_q;
    lt_d      = lt_q;
    verdict_d = verdict_q;
    err_d     = err_q;
    sample_ok = 1'b0;
    sum_d     = '0;

    if (clear) begin
      state_d   = COLLECT;
      gt_d      = '0;
      eq_d      = '0;
      lt_d      = '0;
      verdict_d = 3'b000;
      err_d     = 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (in_valid) begin
            case (y)
              3'b001: begin
                gt_d      = gt_q + ONE;
                sample_ok = 1'b1;
              end
              3'b010: begin
                eq_d      = eq_q + ONE;
                sample_ok = 1'b1;
              end
              3'b100: begin
                lt_d      = lt_q + ONE;
                sample_ok = 1'b1;
              end
              default: begin
                err_d = 1'b1;
              end
            endcase
            sum_d = {2'b00, gt_d} + {2'b00, eq_d} + {2'b00, lt_d};
            // The verdict is taken from the post-increment counts so the
            // final sample of the round is included.
            if (sample_ok && (sum_d == ROUND_TARGET)) begin
              state_d = REPORT;
              if (gt_d > lt_d) begin
                verdict_d = 3'b001;
              end else if (gt_d == lt_d) begin
                verdict_d = 3'b010;
              end else begin
                verdict_d = 3'b100;
              end
            end
          end
        end
        REPORT: begin
          if (res_ready) begin
            state_d   = COLLECT;
            gt_d      = '0;
            eq_d      = '0;
            lt_d      = '0;
            verdict_d = 3'b000;
          end
        end
        default: begin
          state_d = COLLECT;
        end
      endcase
    end
  end

  // State, tally and error registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      gt_q      <= '0;
      eq_q      <= '0;
      lt_q      <= '0;
      verdict_q <= 3'b000;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gt_q      <= gt_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
      verdict_q <= verdict_d;
      err_q     <= err_d;
    end
  end

  assign in_ready  = (state_q == COLLECT);
  assign res_valid = (state_q == REPORT);
  assign gt_cnt    = gt_q;
  assign eq_cnt    = eq_q;
  assign lt_cnt    = lt_q;
  assign verdict   = verdict_q;
  assign err       = err_q;

endmodule

// File: tb/tb_compare_tally.sv
// Testbench for compare_tally: directed vectors with a scoreboard queue of
// expected round results, popped by a monitor whenever res_valid rises.
module tb_compare_tally;

  typedef struct packed {
    logic [3:0] gt;
    logic [3:0] eq;
    logic [3:0] lt;
    logic [2:0] verdict;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] y;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] gt_cnt, eq_cnt, lt_cnt;
  logic [2:0] verdict;
  logic       err;

  logic       r1_clear;
  logic       r1_in_valid;
  logic       r1_in_ready;
  logic [2:0] r1_y;
  logic       r1_res_valid;
  logic       r1_res_ready;
  logic [3:0] r1_gt, r1_eq, r1_lt;
  logic [2:0] r1_verdict;
  logic       r1_err;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t r1_q[$];
  logic prev_valid    = 1'b0;
  logic r1_prev_valid = 1'b0;

  logic [2:0] seq_a [8] = '{3'b001, 3'b100, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
  logic [2:0] seq_b [8] = '{3'b001, 3'b100, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b100};
  logic [2:0] seq_c [10] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b001, 3'b000, 3'b010, 3'b100, 3'b100, 3'b001};

  compare_tally #(.ROUND_LEN(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .y(y),
    .res_valid(res_valid), .res_ready(res_ready),
    .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt),
    .verdict(verdict), .err(err)
  );

  compare_tally #(.ROUND_LEN(1), .CNT_W(4)) dut_r1 (
    .clk(clk), .rst_n(rst_n), .clear(r1_clear),
    .in_valid(r1_in_valid), .in_ready(r1_in_ready), .y(r1_y),
    .res_valid(r1_res_valid), .res_ready(r1_res_ready),
    .gt_cnt(r1_gt), .eq_cnt(r1_eq), .lt_cnt(r1_lt),
    .verdict(r1_verdict), .err(r1_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t makeExp(input int g, input int e, input int l, input logic [2:0] v);
    exp_t r;
    r.gt = 4'(g);
    r.eq = 4'(e);
    r.lt = 4'(l);
    r.verdict = v;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one sample for one clock edge, returning at the following negedge.
  task automatic applyStimulus(input logic [2:0] yv, input logic clr);
    in_valid = 1'b1;
    y        = yv;
    clear    = clr;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  // Monitor for the 8-sample instance: compare each new result against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (res_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_result: got res_valid=1, expected no result at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        checkOutput("sb_gt", 32'(gt_cnt), 32'(e.gt));
        checkOutput("sb_eq", 32'(eq_cnt), 32'(e.eq));
        checkOutput("sb_lt", 32'(lt_cnt), 32'(e.lt));
        checkOutput("sb_verdict", 32'(verdict), 32'(e.verdict));
      end
    end
    prev_valid = res_valid;
  end

  // Monitor for the single-sample-round instance.
  always @(negedge clk) begin
    exp_t e;
    if (r1_res_valid && !r1_prev_valid) begin
      if (r1_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL r1_unexpected_result: got res_valid=1, expected no result at %0t", $time);
      end else begin
        e = r1_q.pop_front();
        checkOutput("r1_gt", 32'(r1_gt), 32'(e.gt));
        checkOutput("r1_eq", 32'(r1_eq), 32'(e.eq));
        checkOutput("r1_lt", 32'(r1_lt), 32'(e.lt));
        checkOutput("r1_verdict", 32'(r1_verdict), 32'(e.verdict));
      end
    end
    r1_prev_valid = r1_res_valid;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; y = 3'b000; res_ready = 1'b0;
    r1_clear = 1'b0; r1_in_valid = 1'b0; r1_y = 3'b000; r1_res_ready = 1'b0;

    // Reset values
    #3;
    checkOutput("rst_res_valid", 32'(res_valid), 0);
    checkOutput("rst_gt", 32'(gt_cnt), 0);
    checkOutput("rst_verdict", 32'(verdict), 0);
    checkOutput("rst_err", 32'(err), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 1);

    // Eight greater-than samples
    exp_q.push_back(makeExp(8, 0, 0, 3'b001));
    for (int i = 0; i < 8; i++) applyStimulus(3'b001, 1'b0);
    checkOutput("t1_in_ready", 32'(in_ready), 0);
    checkOutput("t1_res_valid", 32'(res_valid), 1);
    handshake();
    checkOutput("t1_gt_cleared", 32'(gt_cnt), 0);
    checkOutput("t1_in_ready_back", 32'(in_ready), 1);
    checkOutput("t1_res_valid_low", 32'(res_valid), 0);

    // Mixed sequences: tie then less-than
    exp_q.push_back(makeExp(3, 2, 3, 3'b010));
    for (int i = 0; i < 8; i++) applyStimulus(seq_a[i], 1'b0);
    handshake();
    exp_q.push_back(makeExp(2, 2, 4, 3'b100));
    for (int i = 0; i < 8; i++) applyStimulus(seq_b[i], 1'b0);
    handshake();

    // Malformed samples mixed in; round still closes after 8 valid samples
    exp_q.push_back(makeExp(3, 2, 3, 3'b010));
    for (int i = 0; i < 9; i++) begin
      applyStimulus(seq_c[i], 1'b0);
      if (i == 2) checkOutput("t3_err_set", 32'(err), 1);
    end
    checkOutput("t3_still_collect", 32'(in_ready), 1);
    checkOutput("t3_gt_partial", 32'(gt_cnt), 2);
    applyStimulus(seq_c[9], 1'b0);
    checkOutput("t3_res_valid", 32'(res_valid), 1);
    handshake();
    checkOutput("t3_err_sticky", 32'(err), 1);

    // Stall in REPORT with in_valid high and y toggling
    exp_q.push_back(makeExp(0, 0, 8, 3'b100));
    for (int i = 0; i < 8; i++) applyStimulus(3'b100, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      y = (i % 2 == 0) ? 3'b001 : 3'b010;
      @(posedge clk);
      @(negedge clk);
      checkOutput("t4_in_ready", 32'(in_ready), 0);
      checkOutput("t4_res_valid", 32'(res_valid), 1);
      checkOutput("t4_lt_hold", 32'(lt_cnt), 8);
      checkOutput("t4_gt_hold", 32'(gt_cnt), 0);
      checkOutput("t4_verdict_hold", 32'(verdict), 3'b100);
    end
    in_valid = 1'b1;
    y = 3'b001;
    handshake();
    checkOutput("t4_hs_dropped", 32'(gt_cnt), 0);
    checkOutput("t4_hs_in_ready", 32'(in_ready), 1);
    checkOutput("t4_hs_verdict", 32'(verdict), 0);
    applyStimulus(3'b001, 1'b0);
    checkOutput("t4_first_accept", 32'(gt_cnt), 1);
    checkOutput("t4_err_still", 32'(err), 1);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    checkOutput("t4_clear_err", 32'(err), 0);
    checkOutput("t4_clear_gt", 32'(gt_cnt), 0);

    // Clear on the edge carrying the 8th valid sample
    for (int i = 0; i < 7; i++) applyStimulus(3'b010, 1'b0);
    checkOutput("t5_eq_partial", 32'(eq_cnt), 7);
    applyStimulus(3'b010, 1'b1);
    checkOutput("t5_no_report", 32'(res_valid), 0);
    checkOutput("t5_eq_zero", 32'(eq_cnt), 0);
    checkOutput("t5_in_ready", 32'(in_ready), 1);
    applyStimulus(3'b111, 1'b1);
    checkOutput("t5_bad_with_clear", 32'(err), 0);

    // Asynchronous reset while a report is pending
    exp_q.push_back(makeExp(8, 0, 0, 3'b001));
    for (int i = 0; i < 8; i++) applyStimulus(3'b001, 1'b0);
    checkOutput("t6_res_valid", 32'(res_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_res_valid", 32'(res_valid), 0);
    checkOutput("t6_rst_gt", 32'(gt_cnt), 0);
    checkOutput("t6_rst_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-sample rounds: alternating less/greater, answered immediately
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        r1_q.push_back(makeExp(0, 0, 1, 3'b100));
        r1_y = 3'b100;
      end else begin
        r1_q.push_back(makeExp(1, 0, 0, 3'b001));
        r1_y = 3'b001;
      end
      r1_in_valid  = 1'b1;
      r1_res_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("r1_in_ready_low", 32'(r1_in_ready), 0);
      r1_res_ready = 1'b1;
      r1_in_valid  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      r1_res_ready = 1'b0;
      checkOutput("r1_back_collect", 32'(r1_res_valid), 0);
    end

    @(negedge clk);
    @(negedge clk);
    checkOutput("sb_drain", 32'(exp_q.size()), 0);
    checkOutput("r1_drain", 32'(r1_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
